weapons_bank: RTL and testbench
===============================

WEAPONS_BANK -- requirements
Module: weapons_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent weapon channels (1..16).
REQ-002 Parameter AW, default 9: ammo, capacity and rate width.
REQ-003 Parameter CW, default 4: cooldown counter width.
REQ-004 Parameter RELOAD_CYC, default 8: reload duration in cycles (>=1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 mode_selector  in  4  ship mode; attack mode = 4'b0010.
REQ-008 fire  in  NCH  per-channel fire request, level, sampled every cycle.
REQ-009 reload  in  NCH  per-channel reload request, sampled every cycle.
REQ-010 reload_amt  in  AW  rounds added at reload completion, shared by all channels.
REQ-011 cfg_we / cfg_ch  in  1 / clog2(NCH)  configuration write strobe and target channel.
REQ-012 cfg_max / cfg_rate / cfg_cool  in  AW / AW / CW  capacity, rounds per shot, cooldown cycles.
REQ-013 shot  out  NCH  one-cycle pulse per accepted shot.
REQ-014 error  out  NCH  one-cycle pulse per rejected fire request.
REQ-015 ammo_out  out  NCH*AW  current ammo, channel i at bits [i*AW +: AW].
REQ-016 busy / empty  out  NCH / NCH  channel in COOLDOWN or RELOAD / channel ammo < rate.

Function
REQ-017 Each channel SHALL run its own FSM with states READY, COOLDOWN and RELOAD.
REQ-018 A shot SHALL be accepted in READY when fire=1, mode=attack, rate!=0 and ammo>=rate.
REQ-019 On an accepted shot: shot pulses next cycle; ammo -= rate; cool!=0 -> COOLDOWN with counter=cool; cool=0 -> stay READY.
REQ-020 Fire in READY with wrong mode, rate=0 or ammo<rate SHALL pulse error next cycle and leave ammo and state unchanged.
REQ-021 Fire in COOLDOWN SHALL be ignored silently (held trigger); fire in RELOAD SHALL pulse error.
REQ-022 COOLDOWN SHALL decrement each cycle and return to READY on the cycle the counter reaches 1.
REQ-023 Reload in READY or COOLDOWN SHALL enter RELOAD with counter RELOAD_CYC, aborting any cooldown; reload in RELOAD SHALL be ignored.
REQ-024 Simultaneous reload and fire in READY: reload wins; fire SHALL pulse error.
REQ-025 At RELOAD end: ammo = min(ammo + reload_amt, max), computed at AW+1 bits with no wrap; state -> READY.
REQ-026 A held fire SHALL auto-repeat: one shot per (cool+1) cycles while conditions hold.
REQ-027 cfg_we SHALL update max/rate/cool of cfg_ch at the next edge; cfg_ch>=NCH SHALL be ignored.
REQ-028 If a new max < ammo, ammo SHALL clamp to max on the following cycle.
REQ-029 A cfg write to a channel in flight SHALL NOT alter the current cooldown/reload counter.
REQ-030 Channels SHALL be fully independent; shot, error and ammo of one channel never affect another.
REQ-031 empty SHALL be combinational from the registered ammo and rate.

Reset
REQ-032 While rst=0: all FSMs in READY, ammo=0, max=all-ones, rate=1, cool=0, counters 0, shot=0, error=0.
REQ-033 Reset asserted mid-reload or mid-cooldown SHALL abort immediately with no ammo credit.

Structure
REQ-034 Shared package weapons_pkg SHALL hold the state encoding (READY=0, COOLDOWN=1, RELOAD=2) and the ATTACK_MODE constant.
REQ-035 Each channel SHALL be one instance of sub-module weapon_channel, generated NCH times; the top holds only cfg decode and bus packing.

Verification
REQ-036 Reset, cfg ch0 max=100 rate=3 cool=0, reload_amt=90, reload 1 cycle -> ammo 90 after 8 cycles, busy high during.
REQ-037 Mode=0010, hold fire ch0 for 5 cycles -> 5 shot pulses, ammo 75; mode=0001 fire -> error, ammo 75.
REQ-038 ch1 cool=3 ammo 10 rate 1, hold fire 8 cycles -> 2 shots, ammo 8, no error.
REQ-039 ammo 95 max 100, reload_amt 20 -> ammo 100; then cfg max=50 -> ammo 50 next cycle.
REQ-040 Fire during RELOAD -> error; fire+reload same cycle in READY -> reload entered, error, ammo unchanged.
REQ-041 rst low at reload cycle 4 -> all outputs 0, ammo 0, no credit after release.

Source files
------------

// File: rtl/weapons_pkg.sv
// Shared definitions for the weapons bank: per-channel state encoding and
// the ship mode value that enables firing.
package weapons_pkg;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_RELOAD   = 2'd2
    } ch_state_e;

    localparam logic [3:0] ATTACK_MODE = 4'b0010;

endpackage

// File: rtl/weapon_channel.sv
// One independent weapon channel: fire/cooldown/reload state machine, ammo
// accounting and its own configuration registers.
module weapon_channel
    import weapons_pkg::*;
#(
    parameter int AW         = 9,
    parameter int CW         = 4,
    parameter int RELOAD_CYC = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    mode_i,
    input  logic          fire_i,
    input  logic          reload_i,
    input  logic [AW-1:0] reload_amt_i,
    input  logic          cfg_we_i,
    input  logic [AW-1:0] cfg_max_i,
    input  logic [AW-1:0] cfg_rate_i,
    input  logic [CW-1:0] cfg_cool_i,
    output logic          shot_o,
    output logic          error_o,
    output logic [AW-1:0] ammo_o,
    output logic          busy_o,
    output logic          empty_o
);

    localparam int RW   = $clog2(RELOAD_CYC + 1);
    localparam int CNTW = (RW > CW) ? RW : CW;

    ch_state_e       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   ammo_q, ammo_d, ammo_nx;
    logic [AW-1:0]   max_q, max_d;
    logic [AW-1:0]   rate_q, rate_d;
    logic [CW-1:0]   cool_q, cool_d;
    logic            shot_q, shot_d;
    logic            error_q, error_d;

    logic            can_fire;
    logic [AW:0]     sum;
    logic [AW-1:0]   refill;

    // Refill is summed one bit wider so a large reload saturates at capacity.
    assign sum    = {1'b0, ammo_q} + {1'b0, reload_amt_i};
    assign refill = (sum > {1'b0, max_q}) ? max_q : sum[AW-1:0];

    assign can_fire = (mode_i == ATTACK_MODE) && (rate_q != '0) && (ammo_q >= rate_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ammo_nx = ammo_q;
        shot_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            ST_READY: begin
                if (reload_i) begin
                    state_d = ST_RELOAD;
                    cnt_d   = CNTW'(RELOAD_CYC);
                    error_d = fire_i;
                end else if (fire_i) begin
                    if (can_fire) begin
                        shot_d  = 1'b1;
                        ammo_nx = ammo_q - rate_q;
                        if (cool_q != '0) begin
                            state_d = ST_COOLDOWN;
                            cnt_d   = CNTW'(cool_q);
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                // A held trigger during cooldown is not an error.
                if (reload_i) begin
                    state_d = ST_RELOAD;
                    cnt_d   = CNTW'(RELOAD_CYC);
                end else if (cnt_q <= CNTW'(1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELOAD: begin
                error_d = fire_i;
                if (cnt_q <= CNTW'(1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    ammo_nx = refill;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
        // Capacity lowered by a config write takes effect one cycle later.
        ammo_d = (ammo_nx > max_q) ? max_q : ammo_nx;
    end

    assign max_d  = cfg_we_i ? cfg_max_i  : max_q;
    assign rate_d = cfg_we_i ? cfg_rate_i : rate_q;
    assign cool_d = cfg_we_i ? cfg_cool_i : cool_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            ammo_q  <= '0;
            max_q   <= '1;
            rate_q  <= AW'(1);
            cool_q  <= '0;
            shot_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ammo_q  <= ammo_d;
            max_q   <= max_d;
            rate_q  <= rate_d;
            cool_q  <= cool_d;
            shot_q  <= shot_d;
            error_q <= error_d;
        end
    end

    assign shot_o  = shot_q;
    assign error_o = error_q;
    assign ammo_o  = ammo_q;
    assign busy_o  = (state_q == ST_COOLDOWN) || (state_q == ST_RELOAD);
    assign empty_o = (ammo_q < rate_q);

endmodule

// File: rtl/weapons_bank.sv
// Bank of NCH weapon channels: decodes the shared config port to a channel
// and packs per-channel status onto flat output buses.
module weapons_bank
    import weapons_pkg::*;
#(
    parameter int  NCH        = 4,
    parameter int  AW         = 9,
    parameter int  CW         = 4,
    parameter int  RELOAD_CYC = 8,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [3:0]        mode_selector_i,
    input  logic [NCH-1:0]    fire_i,
    input  logic [NCH-1:0]    reload_i,
    input  logic [AW-1:0]     reload_amt_i,
    input  logic              cfg_we_i,
    input  logic [CHW-1:0]    cfg_ch_i,
    input  logic [AW-1:0]     cfg_max_i,
    input  logic [AW-1:0]     cfg_rate_i,
    input  logic [CW-1:0]     cfg_cool_i,
    output logic [NCH-1:0]    shot_o,
    output logic [NCH-1:0]    error_o,
    output logic [NCH*AW-1:0] ammo_out_o,
    output logic [NCH-1:0]    busy_o,
    output logic [NCH-1:0]    empty_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic cfg_hit;
            // Channel indices beyond NCH never match, so those writes drop.
            assign cfg_hit = cfg_we_i && (cfg_ch_i == CHW'(gi));

            weapon_channel #(
                .AW         (AW),
                .CW         (CW),
                .RELOAD_CYC (RELOAD_CYC)
            ) u_ch (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .mode_i       (mode_selector_i),
                .fire_i       (fire_i[gi]),
                .reload_i     (reload_i[gi]),
                .reload_amt_i (reload_amt_i),
                .cfg_we_i     (cfg_hit),
                .cfg_max_i    (cfg_max_i),
                .cfg_rate_i   (cfg_rate_i),
                .cfg_cool_i   (cfg_cool_i),
                .shot_o       (shot_o[gi]),
                .error_o      (error_o[gi]),
                .ammo_o       (ammo_out_o[gi*AW +: AW]),
                .busy_o       (busy_o[gi]),
                .empty_o      (empty_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_weapons_bank.sv
// Scoreboard bench for weapons_bank: a rule-level model predicts every
// cycle's outputs, a monitor pops and compares them on the falling edge.
module tb_weapons_bank;

    localparam int NCH = 4;
    localparam int AW  = 9;
    localparam int CW  = 4;
    localparam int RC  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [3:0]        mode_selector_i;
    logic [NCH-1:0]    fire_i;
    logic [NCH-1:0]    reload_i;
    logic [AW-1:0]     reload_amt_i;
    logic              cfg_we_i;
    logic [1:0]        cfg_ch_i;
    logic [AW-1:0]     cfg_max_i;
    logic [AW-1:0]     cfg_rate_i;
    logic [CW-1:0]     cfg_cool_i;
    logic [NCH-1:0]    shot_o;
    logic [NCH-1:0]    error_o;
    logic [NCH*AW-1:0] ammo_out_o;
    logic [NCH-1:0]    busy_o;
    logic [NCH-1:0]    empty_o;

    always #5 clk_i = ~clk_i;

    weapons_bank #(.NCH(NCH), .AW(AW), .CW(CW), .RELOAD_CYC(RC)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .mode_selector_i (mode_selector_i),
        .fire_i          (fire_i),
        .reload_i        (reload_i),
        .reload_amt_i    (reload_amt_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_ch_i        (cfg_ch_i),
        .cfg_max_i       (cfg_max_i),
        .cfg_rate_i      (cfg_rate_i),
        .cfg_cool_i      (cfg_cool_i),
        .shot_o          (shot_o),
        .error_o         (error_o),
        .ammo_out_o      (ammo_out_o),
        .busy_o          (busy_o),
        .empty_o         (empty_o)
    );

    typedef struct {
        logic [NCH-1:0]    shot;
        logic [NCH-1:0]    err;
        logic [NCH-1:0]    busy;
        logic [NCH-1:0]    empty;
        logic [NCH*AW-1:0] ammo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Model state: plain integers and "cycles left" counts per channel.
    int m_ammo[NCH], m_max[NCH], m_rate[NCH], m_cool[NCH];
    int m_cool_left[NCH], m_rel_left[NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_ammo[i] = 0; m_max[i] = (1 << AW) - 1; m_rate[i] = 1; m_cool[i] = 0;
            m_cool_left[i] = 0; m_rel_left[i] = 0;
        end
    endtask

    task automatic model_step(output exp_t e);
        e.shot = '0; e.err = '0; e.busy = '0; e.empty = '0; e.ammo = '0;
        for (int i = 0; i < NCH; i++) begin
            bit f, r;
            f = fire_i[i];
            r = reload_i[i];
            if (m_rel_left[i] > 0) begin
                e.err[i] = f;
                if (m_rel_left[i] == 1) begin
                    m_ammo[i] = m_ammo[i] + int'(reload_amt_i);
                    if (m_ammo[i] > m_max[i]) m_ammo[i] = m_max[i];
                end
                m_rel_left[i]--;
            end else if (r) begin
                e.err[i] = f && (m_cool_left[i] == 0);
                m_cool_left[i] = 0;
                m_rel_left[i] = RC;
            end else if (m_cool_left[i] > 0) begin
                m_cool_left[i]--;
            end else if (f) begin
                if (mode_selector_i == 4'b0010 && m_rate[i] != 0 && m_ammo[i] >= m_rate[i]) begin
                    e.shot[i] = 1'b1;
                    m_ammo[i] -= m_rate[i];
                    m_cool_left[i] = m_cool[i];
                end else begin
                    e.err[i] = 1'b1;
                end
            end
            if (m_ammo[i] > m_max[i]) m_ammo[i] = m_max[i];
            if (cfg_we_i && int'(cfg_ch_i) == i) begin
                m_max[i] = int'(cfg_max_i); m_rate[i] = int'(cfg_rate_i); m_cool[i] = int'(cfg_cool_i);
            end
            e.ammo[i*AW +: AW] = AW'(m_ammo[i]);
            e.busy[i]  = (m_cool_left[i] > 0) || (m_rel_left[i] > 0);
            e.empty[i] = (m_ammo[i] < m_rate[i]);
        end
    endtask

    // One clock of stimulus: predict, let the edge happen, hand the
    // prediction to the monitor, then release one-shot inputs.
    task automatic step();
        exp_t e;
        model_step(e);
        @(posedge clk_i);
        exp_q.push_back(e);
        @(negedge clk_i);
        #1;
        cfg_we_i = 1'b0;
        reload_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int cyc);
        fire_i = '0; reload_i = '0; cfg_we_i = 1'b0;
        rst_ni = 1'b0;
        model_reset();
        repeat (cyc) @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic cfg(input int ch, input int mx, input int rt, input int cl);
        cfg_we_i = 1'b1; cfg_ch_i = 2'(ch);
        cfg_max_i = AW'(mx); cfg_rate_i = AW'(rt); cfg_cool_i = CW'(cl);
        step();
    endtask

    task automatic do_reload(input int ch, input int amt);
        reload_amt_i = AW'(amt);
        reload_i[ch] = 1'b1;
        step();
    endtask

    function automatic logic [AW-1:0] ammo_of(input int ch);
        return ammo_out_o[ch*AW +: AW];
    endfunction

    // Monitor: checks reset values while reset is held, otherwise pops one
    // prediction per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_shot",  64'(shot_o),     64'(0));
                chk("rst_error", 64'(error_o),    64'(0));
                chk("rst_ammo",  64'(ammo_out_o), 64'(0));
                chk("rst_busy",  64'(busy_o),     64'(0));
                chk("rst_empty", 64'(empty_o),    64'({NCH{1'b1}}));
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("shot",  64'(shot_o),     64'(e.shot));
                chk("error", 64'(error_o),    64'(e.err));
                chk("ammo",  64'(ammo_out_o), 64'(e.ammo));
                chk("busy",  64'(busy_o),     64'(e.busy));
                chk("empty", 64'(empty_o),    64'(e.empty));
                if ((e.shot | e.err) != '0)
                    $display("txn %0d t=%0t shot=%b error=%b ammo=%h", txn, $time, shot_o, error_o, ammo_out_o);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        mode_selector_i = 4'b0000; fire_i = '0; reload_i = '0; reload_amt_i = '0;
        cfg_we_i = 1'b0; cfg_ch_i = '0; cfg_max_i = '0; cfg_rate_i = '0; cfg_cool_i = '0;
        #2;
        do_reset(2);

        // Initial fill of channel 0
        cfg(0, 100, 3, 0);
        do_reload(0, 90);
        chk("ch0_busy_in_reload", 64'(busy_o[0]), 64'(1));
        idle(8);
        chk("ch0_after_reload", 64'(ammo_of(0)), 64'(90));

        // Held fire with zero cooldown, then wrong mode
        mode_selector_i = 4'b0010;
        fire_i[0] = 1'b1;
        idle(5);
        fire_i[0] = 1'b0;
        chk("ch0_after_5_shots", 64'(ammo_of(0)), 64'(75));
        mode_selector_i = 4'b0001;
        fire_i[0] = 1'b1;
        step();
        fire_i[0] = 1'b0;
        chk("ch0_wrong_mode_error", 64'(error_o[0]), 64'(1));
        chk("ch0_wrong_mode_ammo", 64'(ammo_of(0)), 64'(75));

        // Auto-repeat with cooldown on channel 1
        mode_selector_i = 4'b0010;
        cfg(1, 100, 1, 3);
        do_reload(1, 10);
        idle(8);
        fire_i[1] = 1'b1;
        idle(8);
        fire_i[1] = 1'b0;
        chk("ch1_after_cooldown_fire", 64'(ammo_of(1)), 64'(8));
        idle(4);

        // Saturating reload then capacity clamp on channel 2
        cfg(2, 100, 1, 0);
        do_reload(2, 95);
        idle(8);
        do_reload(2, 20);
        idle(8);
        chk("ch2_saturated", 64'(ammo_of(2)), 64'(100));
        cfg(2, 50, 1, 0);
        step();
        chk("ch2_clamped", 64'(ammo_of(2)), 64'(50));

        // Fire during reload, and fire together with reload
        do_reload(3, 5);
        step();
        fire_i[3] = 1'b1;
        step();
        fire_i[3] = 1'b0;
        chk("ch3_fire_in_reload_error", 64'(error_o[3]), 64'(1));
        idle(7);
        chk("ch3_after_reload", 64'(ammo_of(3)), 64'(5));
        fire_i[3] = 1'b1;
        do_reload(3, 0);
        fire_i[3] = 1'b0;
        chk("ch3_fire_reload_error", 64'(error_o[3]), 64'(1));
        chk("ch3_fire_reload_busy", 64'(busy_o[3]), 64'(1));
        chk("ch3_fire_reload_ammo", 64'(ammo_of(3)), 64'(5));
        idle(8);

        // Reset in the middle of a reload gives no credit
        do_reload(0, 50);
        idle(3);
        do_reset(2);
        idle(10);
        chk("no_credit_after_reset", 64'(ammo_out_o), 64'(0));

        // Randomised traffic
        for (int it = 0; it < 600; it++) begin
            mode_selector_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0010;
            fire_i = NCH'($urandom & $urandom);
            for (int c = 0; c < NCH; c++) reload_i[c] = ($urandom_range(0, 15) == 0);
            reload_amt_i = AW'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) begin
                cfg_we_i = 1'b1; cfg_ch_i = 2'($urandom);
                cfg_max_i = AW'($urandom_range(0, 511));
                cfg_rate_i = AW'($urandom_range(0, 6));
                cfg_cool_i = CW'($urandom_range(0, 3));
            end
            step();
            if (it == 300) do_reset(1);
        end
        fire_i = '0;
        idle(2);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
